// File: rtl/ro_meas_pkg.sv
// Shared definitions for the ring-oscillator measurement blocks:
// measurement FSM states and the default counter widths.
package ro_meas_pkg;

  localparam int GATE_W_DEF = 16;
  localparam int CNT_W_DEF  = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } meas_state_e;

  // A measurement is in progress while arming or counting.
  function automatic logic state_is_busy(input meas_state_e st);
    return (st == ST_ARM) || (st == ST_COUNT);
  endfunction

endpackage

// File: rtl/ro_edge_sync.sv
// Two-flop synchronizer plus rising-edge detector for one oscillator tap.
// rise is high for one cycle when the synchronized input goes 0 -> 1.
module ro_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise
);

  logic sync1_r;
  logic sync2_r;
  logic prev_r;

  // Bring the asynchronous input into the clock domain and keep its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      prev_r  <= 1'b0;
    end else begin
      sync1_r <= sig;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  assign rise = sync2_r & ~prev_r;

endmodule

// File: rtl/ro_freq_counter.sv
// Gated rising-edge counter for the selected ring-oscillator tap.
// Counts synchronized edges over a programmable window of system clocks
// and presents the saturating result with a valid/ack handshake.
module ro_freq_counter
  import ro_meas_pkg::*;
#(
  parameter int GATE_W = GATE_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              ro_sig_i,
  input  logic              start_i,
  input  logic [GATE_W-1:0] gate_len_i,
  input  logic              ack_i,
  output logic [CNT_W-1:0]  count_o,
  output logic              valid_o,
  output logic              overflow_o,
  output logic              busy_o
);

  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [GATE_W-1:0] GATE_ZERO = {GATE_W{1'b0}};
  localparam logic [GATE_W-1:0] GATE_ONE  = {{(GATE_W-1){1'b0}}, 1'b1};

  meas_state_e       state_r;
  meas_state_e       state_s;
  logic [GATE_W-1:0] gate_len_r;
  logic [GATE_W-1:0] gate_cnt_r;
  logic [CNT_W-1:0]  edge_cnt_r;
  logic              overflow_r;
  logic              valid_r;
  logic              busy_r;
  logic              rise_s;
  logic              start_ok_s;

  ro_edge_sync u_edge_sync (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_ni),
    .sig   (ro_sig_i),
    .rise  (rise_s)
  );

  // A start is only accepted when no measurement is running.
  assign start_ok_s = start_i && ((state_r == ST_IDLE) || (state_r == ST_DONE));

  // Next-state logic; a start in DONE wins over a simultaneous ack.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_i) state_s = ST_ARM;
        else         state_s = ST_IDLE;
      end
      ST_ARM: begin
        if (gate_len_r != GATE_ZERO) state_s = ST_COUNT;
        else                         state_s = ST_DONE;
      end
      ST_COUNT: begin
        if (gate_cnt_r == GATE_ONE) state_s = ST_DONE;
        else                        state_s = ST_COUNT;
      end
      ST_DONE: begin
        if (start_i)    state_s = ST_ARM;
        else if (ack_i) state_s = ST_IDLE;
        else            state_s = ST_DONE;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register plus valid/busy flags registered from the next state.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_r <= ST_IDLE;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      valid_r <= (state_s == ST_DONE);
      busy_r  <= state_is_busy(state_s);
    end
  end

  // Latch the window length on an accepted start; run the gate counter down.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      gate_len_r <= GATE_ZERO;
      gate_cnt_r <= GATE_ZERO;
    end else begin
      if (start_ok_s) begin
        gate_len_r <= gate_len_i;
      end
      if (state_r == ST_ARM) begin
        gate_cnt_r <= gate_len_r;
      end else if (state_r == ST_COUNT) begin
        gate_cnt_r <= gate_cnt_r - GATE_ONE;
      end
    end
  end

  // Saturating edge counter with sticky overflow, both cleared while arming.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      edge_cnt_r <= CNT_ZERO;
      overflow_r <= 1'b0;
    end else begin
      if (state_r == ST_ARM) begin
        edge_cnt_r <= CNT_ZERO;
        overflow_r <= 1'b0;
      end else if ((state_r == ST_COUNT) && rise_s) begin
        if (edge_cnt_r == CNT_MAX) overflow_r <= 1'b1;
        else                       edge_cnt_r <= edge_cnt_r + CNT_ONE;
      end
    end
  end

  assign count_o    = edge_cnt_r;
  assign overflow_o = overflow_r;
  assign valid_o    = valid_r;
  assign busy_o     = busy_r;

endmodule

// File: tb/tb_ro_freq_counter.sv
// Randomized scoreboard bench for ro_freq_counter. The oscillator input is
// a square wave defined as a function of the clock-cycle index; expected
// counts are the number of 0->1 transitions of that wave inside the window
// the measurement observes, saturated to the counter width.
module tb_ro_freq_counter;

  localparam longint MAIN_MAX  = 64'd16777215;
  localparam longint SMALL_MAX = 64'd15;

  typedef struct {
    longint cnt;
    bit     ovf;
    int     s;
    int     n;
  } exp_t;

  logic        wb_clk_i;
  logic        wb_rst_ni;
  logic        ro_sig_i;
  logic        start_i;
  logic [15:0] gate_len_i;
  logic        ack_i;
  logic [23:0] count_o;
  logic        valid_o;
  logic        overflow_o;
  logic        busy_o;

  logic        start2;
  logic [7:0]  gate2;
  logic        ack2;
  logic [3:0]  count2;
  logic        valid2;
  logic        ovf2;
  logic        busy2;

  int   tests = 0;
  int   fails = 0;
  exp_t sb_q[$];

  int per_r   = 3;
  int ph_r    = 0;
  bit quiet_r = 1'b0;

  ro_freq_counter u_dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_ni  (wb_rst_ni),
    .ro_sig_i   (ro_sig_i),
    .start_i    (start_i),
    .gate_len_i (gate_len_i),
    .ack_i      (ack_i),
    .count_o    (count_o),
    .valid_o    (valid_o),
    .overflow_o (overflow_o),
    .busy_o     (busy_o)
  );

  ro_freq_counter #(.GATE_W(8), .CNT_W(4)) u_small (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_ni  (wb_rst_ni),
    .ro_sig_i   (ro_sig_i),
    .start_i    (start2),
    .gate_len_i (gate2),
    .ack_i      (ack2),
    .count_o    (count2),
    .valid_o    (valid2),
    .overflow_o (ovf2),
    .busy_o     (busy2)
  );

  initial begin
    wb_clk_i = 1'b0;
    forever #5 wb_clk_i = ~wb_clk_i;
  end

  // Square-wave value presented to the posedge with index k.
  function automatic bit wave(input int k);
    if (quiet_r) return 1'b0;
    return ((k + ph_r) % per_r) < (per_r / 2);
  endfunction

  // Edges seen by a window of n cycles whose start is sampled at posedge s:
  // transitions whose detection lands in the counting cycles.
  function automatic longint ref_edges(input int s, input int n);
    longint c = 0;
    for (int i = s - 1; i <= s + n - 2; i++)
      if (!wave(i) && wave(i + 1)) c++;
    return c;
  endfunction

  // Posedges at 5+10k; the negedge at 10k sets the value sampled at posedge k.
  initial begin
    ro_sig_i = 1'b0;
    forever begin
      @(negedge wb_clk_i);
      ro_sig_i = wave(int'($time) / 10);
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: on every new result pop the scoreboard and compare value,
  // overflow, result timing and the length of the preceding busy run.
  initial begin : monitor
    bit   pv;
    int   run;
    int   last_run;
    int   k;
    exp_t e;
    pv = 1'b0; run = 0; last_run = 0;
    forever begin
      @(posedge wb_clk_i);
      #1;
      k = (int'($time) - 6) / 10;
      if (!wb_rst_ni) begin
        pv = 1'b0; run = 0; last_run = 0;
      end else begin
        if (busy_o && valid_o) check("busy_and_valid", 1, 0);
        if (busy_o) run++;
        else if (run != 0) begin
          last_run = run; run = 0;
        end
        if (valid_o && !pv) begin
          if (sb_q.size() == 0) begin
            check("unexpected_valid", 1, 0);
          end else begin
            e = sb_q.pop_front();
            check("count", longint'(count_o), e.cnt);
            check("overflow", longint'(overflow_o), longint'(e.ovf));
            check("valid_cycle", k, e.s + e.n + 1);
            check("busy_len", last_run, e.n + 1);
          end
        end
        pv = valid_o;
      end
    end
  end

  task automatic set_wave(input int p, input int ph, input bit q);
    per_r = p; ph_r = ph; quiet_r = q;
    repeat (6) @(negedge wb_clk_i);
  endtask

  task automatic start_meas(input int n, input bit with_ack, output longint exp_cnt);
    exp_t   e;
    longint raw;
    @(negedge wb_clk_i);
    start_i = 1'b1; ack_i = with_ack; gate_len_i = n[15:0];
    e.s = int'($time) / 10;
    e.n = n;
    raw = ref_edges(e.s, n);
    e.cnt = (raw > MAIN_MAX) ? MAIN_MAX : raw;
    e.ovf = (raw > MAIN_MAX);
    exp_cnt = e.cnt;
    sb_q.push_back(e);
    @(negedge wb_clk_i);
    start_i = 1'b0; ack_i = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (valid_o) begin
        ok = 1'b1;
        break;
      end
      @(negedge wb_clk_i);
    end
    if (!ok) check("valid_timeout", 0, 1);
  endtask

  task automatic ack_and_check();
    @(negedge wb_clk_i);
    ack_i = 1'b1;
    @(negedge wb_clk_i);
    ack_i = 1'b0;
    check("valid_after_ack", longint'(valid_o), 0);
  endtask

  task automatic measure(input int n, input int hold);
    longint ec;
    start_meas(n, 1'b0, ec);
    wait_valid(n + 10);
    repeat (hold) @(negedge wb_clk_i);
    check("held_count", longint'(count_o), ec);
    check("held_valid", longint'(valid_o), 1);
    ack_and_check();
  endtask

  task automatic small_meas(input int n, input longint max_v);
    int     s;
    longint raw;
    bit     ok = 1'b0;
    @(negedge wb_clk_i);
    start2 = 1'b1; gate2 = n[7:0];
    s = int'($time) / 10;
    raw = ref_edges(s, n);
    @(negedge wb_clk_i);
    start2 = 1'b0;
    for (int i = 0; i < n + 10; i++) begin
      if (valid2) begin
        ok = 1'b1;
        break;
      end
      @(negedge wb_clk_i);
    end
    if (!ok) check("small_valid_timeout", 0, 1);
    check("small_count", longint'(count2), (raw > max_v) ? max_v : raw);
    check("small_overflow", longint'(ovf2), longint'(raw > max_v));
    @(negedge wb_clk_i);
    ack2 = 1'b1;
    @(negedge wb_clk_i);
    ack2 = 1'b0;
  endtask

  initial begin : stim
    longint ec;
    wb_rst_ni = 1'b0;
    start_i = 1'b0; ack_i = 1'b0; gate_len_i = 16'd0;
    start2 = 1'b0; ack2 = 1'b0; gate2 = 8'd0;

    // Reset held with the input toggling: every output stays at zero.
    repeat (3) begin
      @(negedge wb_clk_i);
      check("reset_outputs", {count_o, valid_o, overflow_o, busy_o}, 0);
    end
    wb_rst_ni = 1'b1;
    repeat (8) begin
      @(negedge wb_clk_i);
      check("idle_no_activity", {valid_o, busy_o}, 0);
    end

    // Basic measurement: period 4 over 100 cycles.
    set_wave(4, 0, 1'b0);
    measure(100, 4);

    // Zero-length window.
    measure(0, 2);

    // Start and ack while counting are both ignored.
    set_wave(5, 2, 1'b0);
    start_meas(80, 1'b0, ec);
    repeat (20) @(negedge wb_clk_i);
    start_i = 1'b1; gate_len_i = 16'd5; ack_i = 1'b1;
    @(negedge wb_clk_i);
    start_i = 1'b0; ack_i = 1'b0;
    check("busy_after_ignored_start", longint'(busy_o), 1);
    wait_valid(80);
    ack_and_check();

    // Start together with ack in DONE re-arms and drops valid next cycle.
    set_wave(3, 1, 1'b0);
    start_meas(30, 1'b0, ec);
    wait_valid(40);
    start_meas(40, 1'b1, ec);
    check("rearm_valid_dropped", longint'(valid_o), 0);
    check("rearm_busy", longint'(busy_o), 1);
    wait_valid(50);
    ack_and_check();

    // Randomized measurements.
    for (int t = 0; t < 16; t++) begin
      int p;
      int n;
      p = int'($urandom_range(9, 2));
      set_wave(p, int'($urandom_range(p - 1, 0)), ($urandom_range(7, 0) == 0));
      if ($urandom_range(4, 0) == 0) n = int'($urandom_range(2, 0));
      else                           n = int'($urandom_range(250, 3));
      measure(n, int'($urandom_range(3, 0)));
    end

    // Saturation on the 4-bit counter, then a quiet run clears overflow.
    set_wave(2, 0, 1'b0);
    small_meas(64, SMALL_MAX);
    set_wave(2, 0, 1'b1);
    small_meas(10, SMALL_MAX);

    // Asynchronous reset in the middle of a window.
    set_wave(4, 1, 1'b0);
    start_meas(200, 1'b0, ec);
    repeat (50) @(negedge wb_clk_i);
    @(posedge wb_clk_i);
    #3;
    wb_rst_ni = 1'b0;
    #1;
    check("async_reset_outputs", {count_o, valid_o, overflow_o, busy_o}, 0);
    sb_q.delete();
    repeat (2) @(negedge wb_clk_i);
    wb_rst_ni = 1'b1;
    set_wave(6, 3, 1'b0);
    measure(50, 1);

    repeat (5) @(negedge wb_clk_i);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
